bus_uart_tx: RTL and testbench
==============================

# bus_uart_tx

Memory-mapped UART transmitter that responds to processor bus writes and reads on the shared 8-bit bus. It buffers bytes in an internal FIFO and serialises them as 8N1 frames on a TX pin. It raises a processor interrupt when the FIFO has drained and the line is idle. It sits beside the timer, mouse, seven-segment and VGA peripherals and adds an outbound serial channel.

## Interface
- BASE_ADDR, 8'hE0, first of three consecutive bus addresses
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200)
- FIFO_DEPTH, 8, TX FIFO entries (power of two)
- CLK  in  1  system clock, all logic on rising edge
- RESET  in  1  asynchronous, active-low reset
- BUS_DATA  inout  8  shared data bus, high-Z unless this block is reading out
- BUS_ADDR  in  8  bus address
- BUS_WE  in  1  bus write enable
- BUS_INTERRUPT_RAISE  out  1  interrupt request, level, held until acked
- BUS_INTERRUPT_ACK  in  1  one-cycle acknowledge from processor
- TX  out  1  serial output, idle high

## Operation
- Register map (offset from BASE_ADDR):
  - +0 DATA: a write pushes BUS_DATA into the FIFO; a read returns the FIFO count (0..FIFO_DEPTH).
  - +1 STATUS: a read returns {4'b0, overflow, empty, full, busy}; any write clears overflow.
  - +2 CTRL: read/write; bit0 tx_enable, bit1 irq_enable; reset value 8'h00.
- Bus reads are registered. An address match with BUS_WE=0 at edge k drives BUS_DATA during the cycle after k. Otherwise BUS_DATA is high-Z.
- A write to DATA when the FIFO is full is dropped and sets sticky overflow.
- A push and a pop in the same cycle on a full FIFO: the push is accepted.
- Serialiser FSM has states IDLE, START, DATA, STOP (plus PARITY when configured):
  - IDLE: if tx_enable and FIFO not empty, pop into the shift register and go to START.
  - START: TX=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each.
  - STOP: TX=1 for CLKS_PER_BIT cycles. On its last cycle, if tx_enable and FIFO not empty, pop and go straight to START (gapless). Otherwise go to IDLE.
- busy = state != IDLE.
- Interrupt:
  - On the STOP→IDLE transition with the FIFO empty and irq_enable=1, set RAISE.
  - RAISE clears on the cycle after ACK=1.
  - If a new set event and ACK occur in the same cycle, RAISE stays 1.
- Clearing tx_enable mid-frame: the current frame completes, then the FSM goes to IDLE and the FIFO is retained.

## Timing
- Reset values: TX=1, BUS_INTERRUPT_RAISE=0, BUS_DATA high-Z, FIFO empty, overflow=0, CTRL=0, state IDLE.
- Reset asserted mid-frame: TX returns to 1 immediately (asynchronous) and the FIFO contents are lost.
- Write to DATA at edge k, FIFO previously empty, tx_enable=1: pop at edge k+1, TX low from edge k+2.
- Frame length: exactly 10·CLKS_PER_BIT cycles (11· with parity). No idle cycles between back-to-back bytes.
- Read latency: 1 cycle. Write effect: visible at the next edge.
- Bit counter wraps at 7. The baud counter runs 0..CLKS_PER_BIT-1 and restarts at each bit boundary.

## Configuration
- UART_TX_PARITY_EN defined:
  - PARITY state inserted between DATA and STOP, transmitting even parity of the 8 data bits for CLKS_PER_BIT cycles.
  - CTRL bit2 selects odd parity when 1.
- Undefined: no PARITY state, CTRL bit2 reads 0 and ignores writes, 8N1 only.

## Structure
- Package bus_uart_pkg:
  - register offset constants DATA_OFS/STATUS_OFS/CTRL_OFS
  - STATUS and CTRL bit index constants
  - tx_state_t enum
- Sub-module uart_tx_fifo: synchronous FIFO with push/pop/full/empty/count and the simultaneous push-pop-on-full rule above.
- Top handles bus decode, registered readback, tristate, FSM and interrupt logic.

## Test plan
- CTRL=8'h03, write 8'hA5 to DATA -> TX low from 2 cycles after the write. Bits 1,0,1,0,0,1,0,1 (LSB first), each 868 cycles, then stop bit high. RAISE asserts at the STOP→IDLE edge.
- Write 3 bytes back-to-back -> 3 contiguous frames totalling 30·868 cycles with no gap. A DATA read mid-stream returns the decreasing count.
- With tx_enable=0, write 9 bytes -> count=8, STATUS=8'h0A (overflow, full). A write to STATUS -> 8'h02.
- RAISE high, pulse ACK -> RAISE low next cycle. ACK coincident with a new completion -> RAISE stays 1.
- Assert RESET mid-DATA -> TX=1, count 0, RAISE 0 without waiting for a clock. After release, idle until a new write.
- With UART_TX_PARITY_EN, send 8'h07 -> parity bit 1 (even). With CTRL bit2=1 -> parity bit 0. Frame is 11·868 cycles.

Source files
------------

// File: rtl/bus_uart_pkg.sv
// bus_uart_pkg: shared constants and types for the bus-mapped UART transmitter.
//   - register offsets relative to BASE_ADDR
//   - STATUS / CTRL bit positions
//   - serialiser state type
package bus_uart_pkg;

    // Register offsets (low two bits of BUS_ADDR - BASE_ADDR)
    localparam logic [1:0] DATA_OFS   = 2'd0;
    localparam logic [1:0] STATUS_OFS = 2'd1;
    localparam logic [1:0] CTRL_OFS   = 2'd2;

    // STATUS = {4'b0, overflow, empty, full, busy}
    localparam int unsigned BUSY_BIT  = 0;
    localparam int unsigned FULL_BIT  = 1;
    localparam int unsigned EMPTY_BIT = 2;
    localparam int unsigned OVF_BIT   = 3;

    // CTRL bits
    localparam int unsigned TX_EN_BIT  = 0;
    localparam int unsigned IRQ_EN_BIT = 1;
    localparam int unsigned ODD_BIT    = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO holding bytes awaiting transmission.
// Ports:
//   CLK, RESET     - clock, asynchronous active-low reset (clears contents)
//   push, din      - write request and data; accepted when not full, or when
//                    a pop happens in the same cycle
//   pop            - read request; ignored when empty
//   dout           - head-of-queue data (valid when !empty)
//   full, empty    - occupancy flags
//   count          - current number of entries, 0..DEPTH
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (count_q == FULL_CNT);
        empty   = (count_q == '0);
        do_pop  = pop && !empty;
        // A pop frees a slot in the same cycle, so a full FIFO still takes the push
        do_push = push && (!full || do_pop);
        dout    = mem_q[rd_ptr_q];
        count   = count_q;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/bus_uart_tx.sv
// bus_uart_tx: memory-mapped UART transmitter on the shared 8-bit processor bus.
// Registers at BASE_ADDR + {0: DATA, 1: STATUS, 2: CTRL}; bytes are queued in a
// FIFO and sent as 8N1 frames (8E1/8O1 when UART_TX_PARITY_EN is defined).
// Ports:
//   CLK                 - system clock
//   RESET               - asynchronous active-low reset
//   BUS_DATA            - shared data bus, driven only the cycle after a read hit
//   BUS_ADDR, BUS_WE    - bus address and write enable
//   BUS_INTERRUPT_RAISE - level interrupt, set when the FIFO drains and the line idles
//   BUS_INTERRUPT_ACK   - processor acknowledge, clears RAISE at the next edge
//   TX                  - serial output, idle high
// Build option: `define UART_TX_PARITY_EN adds a parity bit (CTRL bit2 = odd).
module bus_uart_tx
    import bus_uart_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR    = 8'hE0,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK,
    output logic       TX
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
    localparam int unsigned CTRL_W = 3;
`else
    localparam int unsigned CTRL_W = 2;
`endif

    logic [7:0]        ofs;
    logic              hit;
    logic              rd_en;
    logic              data_wr;
    logic              status_wr;
    logic              ctrl_wr;
    logic [7:0]        status;
    logic [7:0]        rd_mux;

    logic [CTRL_W-1:0] ctrl_q;
    logic              ovf_q;
    logic [7:0]        rd_data_q;
    logic              rd_oe_q;

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_dout;
    logic [CW-1:0]     fifo_count;

    tx_state_t         state_q;
    logic [BW-1:0]     baud_q;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q;
    logic              tx_q;
    logic              raise_q;
    logic              baud_last;
    logic              stop_done;
    logic              irq_set;
`ifdef UART_TX_PARITY_EN
    logic              par_q;
`endif

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (data_wr),
        .din   (BUS_DATA),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        ofs       = BUS_ADDR - BASE_ADDR;
        hit       = (BUS_ADDR >= BASE_ADDR) && (ofs < 8'd3);
        rd_en     = hit && !BUS_WE;
        data_wr   = hit && BUS_WE && (ofs[1:0] == DATA_OFS);
        status_wr = hit && BUS_WE && (ofs[1:0] == STATUS_OFS);
        ctrl_wr   = hit && BUS_WE && (ofs[1:0] == CTRL_OFS);

        baud_last = (baud_q == BAUD_LAST);
        stop_done = (state_q == StStop) && baud_last;
        // Pop from idle, or on the last stop-bit cycle for gapless back-to-back frames
        fifo_pop  = ctrl_q[TX_EN_BIT] && !fifo_empty && ((state_q == StIdle) || stop_done);
        irq_set   = stop_done && !fifo_pop && fifo_empty && ctrl_q[IRQ_EN_BIT];

        status            = 8'h00;
        status[BUSY_BIT]  = (state_q != StIdle);
        status[FULL_BIT]  = fifo_full;
        status[EMPTY_BIT] = fifo_empty;
        status[OVF_BIT]   = ovf_q;

        case (ofs[1:0])
            DATA_OFS:   rd_mux = 8'(fifo_count);
            STATUS_OFS: rd_mux = status;
            CTRL_OFS:   rd_mux = 8'(ctrl_q);
            default:    rd_mux = 8'h00;
        endcase
    end

    // Registered readback: value captured at the read edge, driven for one cycle
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ctrl_q    <= '0;
            ovf_q     <= 1'b0;
            rd_data_q <= 8'h00;
            rd_oe_q   <= 1'b0;
        end else begin
            rd_oe_q <= rd_en;
            if (rd_en) rd_data_q <= rd_mux;
            if (ctrl_wr) ctrl_q <= BUS_DATA[CTRL_W-1:0];
            if (status_wr) begin
                ovf_q <= 1'b0;
            end else if (data_wr && fifo_full && !fifo_pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign BUS_DATA = rd_oe_q ? rd_data_q : 8'hzz;

    // Serialiser; TX is registered so it trails the state by one cycle
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    tx_q   <= 1'b1;
                    baud_q <= '0;
                    if (fifo_pop) begin
                        shift_q <= fifo_dout;
`ifdef UART_TX_PARITY_EN
                        par_q   <= (^fifo_dout) ^ ctrl_q[ODD_BIT];
`endif
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    tx_q <= 1'b0;
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= 3'd0;
                        state_q <= StData;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StData: begin
                    tx_q <= shift_q[0];
                    if (baud_last) begin
                        baud_q  <= '0;
                        shift_q <= {1'b0, shift_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    tx_q <= par_q;
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= StStop;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`endif
                StStop: begin
                    tx_q <= 1'b1;
                    if (baud_last) begin
                        baud_q <= '0;
                        if (fifo_pop) begin
                            shift_q <= fifo_dout;
`ifdef UART_TX_PARITY_EN
                            par_q   <= (^fifo_dout) ^ ctrl_q[ODD_BIT];
`endif
                            state_q <= StStart;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    baud_q  <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // A new completion wins over a coincident acknowledge
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            raise_q <= 1'b0;
        end else if (irq_set) begin
            raise_q <= 1'b1;
        end else if (BUS_INTERRUPT_ACK) begin
            raise_q <= 1'b0;
        end
    end

    assign TX                  = tx_q;
    assign BUS_INTERRUPT_RAISE = raise_q;

endmodule

// File: tb/tb_bus_uart_tx.sv
module tb_bus_uart_tx;

    localparam int C = 16;
    localparam int D = 8;
    localparam logic [7:0] BASE   = 8'hE0;
    localparam logic [7:0] A_DATA = BASE;
    localparam logic [7:0] A_STAT = BASE + 8'd1;
    localparam logic [7:0] A_CTRL = BASE + 8'd2;
`ifdef UART_TX_PARITY_EN
    localparam int FLEN = 11;
    localparam logic [7:0] CTRL_MASK = 8'h07;
`else
    localparam int FLEN = 10;
    localparam logic [7:0] CTRL_MASK = 8'h03;
`endif
    localparam int F = FLEN * C;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic [7:0] addr   = 8'h00;
    logic       we     = 1'b0;
    logic       drv_en = 1'b0;
    logic [7:0] drv    = 8'h00;
    logic       ack    = 1'b0;
    wire  [7:0] bus_data;
    wire        raise;
    wire        tx;

    assign bus_data = drv_en ? drv : 8'hzz;

    bus_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .CLK                 (clk),
        .RESET               (rst_n),
        .BUS_DATA            (bus_data),
        .BUS_ADDR            (addr),
        .BUS_WE              (we),
        .BUS_INTERRUPT_RAISE (raise),
        .BUS_INTERRUPT_ACK   (ack),
        .TX                  (tx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Behavioural model: frame schedule in edge numbers, byte queue, raise flag
    int          cyc = 0;
    logic [7:0]  m_q[$];
    bit          m_act = 1'b0;
    int          m_s = 0;
    logic [10:0] m_frame = '1;
    logic        m_tx = 1'b1;
    logic        m_raise = 1'b0;
    logic [7:0]  m_ctrl = 8'h00;

    always @(posedge clk) begin : model
        int   sz0;
        bit   popped;
        bit   ended;
        logic [7:0] b;
        cyc = cyc + 1;
        if (!rst_n) begin
            m_q.delete();
            m_act   = 1'b0;
            m_tx    = 1'b1;
            m_raise = 1'b0;
            m_ctrl  = 8'h00;
        end else begin
            sz0    = m_q.size();
            popped = 1'b0;
            ended  = 1'b0;
            m_tx   = m_act ? m_frame[(cyc - 1 - m_s) / C] : 1'b1;
            if (m_act && cyc == m_s + F) begin
                m_act = 1'b0;
                ended = 1'b1;
            end
            if (!m_act && m_ctrl[0] && sz0 > 0) begin
                b = m_q.pop_front();
`ifdef UART_TX_PARITY_EN
                m_frame = {1'b1, (^b) ^ m_ctrl[2], b, 1'b0};
`else
                m_frame = {2'b11, b, 1'b0};
`endif
                m_s    = cyc;
                m_act  = 1'b1;
                popped = 1'b1;
            end
            if (ended && !popped && sz0 == 0 && m_ctrl[1]) m_raise = 1'b1;
            else if (ack) m_raise = 1'b0;
            if (we && addr == A_DATA && (sz0 < D || popped)) m_q.push_back(drv);
            if (we && addr == A_CTRL) m_ctrl = drv & CTRL_MASK;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            n_tests++;
            if (tx !== m_tx) begin
                n_fail++;
                $display("FAIL model_tx edge %0d: got %b, expected %b", cyc, tx, m_tx);
            end
            n_tests++;
            if (raise !== m_raise) begin
                n_fail++;
                $display("FAIL model_raise edge %0d: got %b, expected %b", cyc, raise, m_raise);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h, expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic goto(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; we = 1'b1; drv = d; drv_en = 1'b1;
        @(negedge clk);
        addr = 8'h00; we = 1'b0; drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; we = 1'b0; drv_en = 1'b0;
        @(negedge clk);
        d = bus_data;
        addr = 8'h00;
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    logic a5_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        int k;
        logic [7:0] rd;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("reset_tx", {7'b0, tx}, 8'h01);
        chk("reset_raise", {7'b0, raise}, 8'h00);
        bus_read(A_STAT, rd); chk("reset_status", rd, 8'h04);
        bus_read(A_DATA, rd); chk("reset_count", rd, 8'h00);
        bus_read(A_CTRL, rd); chk("reset_ctrl", rd, 8'h00);

        // Single byte 0xA5
        bus_write(A_CTRL, 8'h03);
        bus_write(A_DATA, 8'hA5);
        k = cyc;
        goto(k + 1); chk("a5_latency_hi", {7'b0, tx}, 8'h01);
        goto(k + 2); chk("a5_start_lo", {7'b0, tx}, 8'h00);
        for (int i = 0; i < 9; i++) begin
            goto(k + 2 + i * C + C / 2);
            chk($sformatf("a5_bit%0d", i), {7'b0, tx}, {7'b0, a5_bits[i]});
        end
        goto(k + 2 + (FLEN - 1) * C + C / 2); chk("a5_stop", {7'b0, tx}, 8'h01);
        goto(k + F); chk("a5_raise_pre", {7'b0, raise}, 8'h00);
        goto(k + 1 + F); chk("a5_raise", {7'b0, raise}, 8'h01);
        goto(k + 5 + F); chk("a5_raise_held", {7'b0, raise}, 8'h01);
        ack_pulse(); chk("ack_clear", {7'b0, raise}, 8'h00);

        // Three back-to-back bytes
        bus_write(A_DATA, 8'h11);
        k = cyc;
        bus_write(A_DATA, 8'h22);
        bus_write(A_DATA, 8'h33);
        goto(k + 2 * C);
        bus_read(A_DATA, rd); chk("b2b_count2", rd, 8'h02);
        bus_read(A_STAT, rd); chk("b2b_status", rd, 8'h01);
        goto(k + 1 + F); chk("b2b_stop1", {7'b0, tx}, 8'h01);
        goto(k + 2 + F); chk("b2b_start2", {7'b0, tx}, 8'h00);
        goto(k + 1 + F + C);
        bus_read(A_DATA, rd); chk("b2b_count1", rd, 8'h01);
        goto(k + 1 + 2 * F + C);
        bus_read(A_DATA, rd); chk("b2b_count0", rd, 8'h00);
        goto(k + 3 * F); chk("b2b_raise_pre", {7'b0, raise}, 8'h00);
        goto(k + 1 + 3 * F); chk("b2b_raise", {7'b0, raise}, 8'h01);
        ack_pulse(); chk("b2b_ack", {7'b0, raise}, 8'h00);

        // ACK on the same edge as a new completion
        bus_write(A_DATA, 8'h3C);
        k = cyc;
        goto(k + F); chk("coinc_pre", {7'b0, raise}, 8'h00);
        ack = 1'b1;
        goto(k + 1 + F);
        ack = 1'b0;
        chk("coinc_raise", {7'b0, raise}, 8'h01);

        // Overflow with transmitter disabled; RAISE left pending
        bus_write(A_CTRL, 8'h00);
        for (int i = 0; i < 9; i++) bus_write(A_DATA, 8'(i));
        bus_read(A_DATA, rd); chk("ovf_count", rd, 8'h08);
        bus_read(A_STAT, rd); chk("ovf_status", rd, 8'h0A);
        bus_write(A_STAT, 8'hFF);
        bus_read(A_STAT, rd); chk("ovf_cleared", rd, 8'h02);
        chk("ovf_raise_kept", {7'b0, raise}, 8'h01);

        // Reset in the middle of a frame (byte 0x00: data bits low)
        bus_write(A_CTRL, 8'h01);
        k = cyc;
        goto(k + 2 + 3 * C); chk("rst_pre_tx", {7'b0, tx}, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_tx", {7'b0, tx}, 8'h01);
        chk("rst_async_raise", {7'b0, raise}, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_read(A_DATA, rd); chk("rst_count", rd, 8'h00);
        bus_read(A_STAT, rd); chk("rst_status", rd, 8'h04);
        bus_read(A_CTRL, rd); chk("rst_ctrl", rd, 8'h00);
        goto(cyc + 2 * C); chk("rst_idle_tx", {7'b0, tx}, 8'h01);

        // CTRL masking and a fresh frame after reset
        bus_write(A_CTRL, 8'hFF);
        bus_read(A_CTRL, rd); chk("ctrl_mask", rd, CTRL_MASK);
        bus_write(A_CTRL, 8'h03);
        bus_write(A_DATA, 8'h5A);
        k = cyc;
        goto(k + 1 + F); chk("post_rst_raise", {7'b0, raise}, 8'h01);
        ack_pulse();

`ifdef UART_TX_PARITY_EN
        bus_write(A_DATA, 8'h07);
        k = cyc;
        goto(k + 2 + 9 * C + C / 2); chk("par_even", {7'b0, tx}, 8'h01);
        goto(k + 1 + F);
        ack_pulse();
        bus_write(A_CTRL, 8'h07);
        bus_write(A_DATA, 8'h07);
        k = cyc;
        goto(k + 2 + 9 * C + C / 2); chk("par_odd", {7'b0, tx}, 8'h00);
        goto(k + F); chk("par_len_pre", {7'b0, raise}, 8'h00);
        goto(k + 1 + F); chk("par_len", {7'b0, raise}, 8'h01);
`endif

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
